// File: rtl/mux_sel_scanner_if.sv
// Control and display-select bundle between the scan controller and its user; mask exists only with SCAN_MASK_EN.
// master drives en/hold/manual/man_sel(/mask) and observes sel/an_n/tick/frame; slave is the scanner.
interface mux_sel_scanner_if;
  logic       en;
  logic       hold;
  logic       manual;
  logic [1:0] man_sel;
`ifdef SCAN_MASK_EN
  logic [3:0] mask;
`endif
  logic [1:0] sel;
  logic [3:0] an_n;
  logic       tick;
  logic       frame;

`ifdef SCAN_MASK_EN
  modport master (output en, hold, manual, man_sel, mask, input sel, an_n, tick, frame);
  modport slave  (input en, hold, manual, man_sel, mask, output sel, an_n, tick, frame);
`else
  modport master (output en, hold, manual, man_sel, input sel, an_n, tick, frame);
  modport slave  (input en, hold, manual, man_sel, output sel, an_n, tick, frame);
`endif
endinterface

// File: rtl/mux_sel_scanner.sv
// Prescaled round-robin 4:1 mux select scanner with hold and manual override; SCAN_MASK_EN adds a per-channel skip mask.
// Latency: sel/tick/frame registered on the deciding edge; an_n decoded from state and sel with no extra cycle.
// Backpressure: none; hold freezes sel while the prescaler runs, en=0 freezes all state and blanks an_n.
module mux_sel_scanner #(
  parameter int unsigned DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  mux_sel_scanner_if.slave bus
);
  localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SCAN, MANUAL} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] psc, psc_nxt;
  logic [1:0]    sel_q, sel_nxt;
  logic          tick_q, tick_nxt;
  logic          frame_q, frame_nxt;
  logic [1:0]    adv_sel;
  logic          adv_ok;
  logic          all_masked;
  logic [3:0]    an_d;

`ifdef SCAN_MASK_EN
  logic [1:0] cand;

  // Search sel+1 .. sel+4 so the current channel is the last resort.
  always_comb begin
    adv_sel = sel_q;
    adv_ok  = 1'b0;
    cand    = sel_q;
    for (int k = 1; k <= 4; k++) begin
      cand = sel_q + 2'(k);
      if (!adv_ok && !bus.mask[cand]) begin
        adv_sel = cand;
        adv_ok  = 1'b1;
      end
    end
  end

  assign all_masked = &bus.mask;
`else
  assign adv_sel    = sel_q + 2'd1;
  assign adv_ok     = 1'b1;
  assign all_masked = 1'b0;
`endif

  // Register updates follow the state being entered on this edge.
  always_comb begin
    state_nxt = state;
    psc_nxt   = psc;
    sel_nxt   = sel_q;
    tick_nxt  = 1'b0;
    frame_nxt = 1'b0;

    if (!bus.en)          state_nxt = IDLE;
    else if (bus.manual)  state_nxt = MANUAL;
    else                  state_nxt = SCAN;

    case (state_nxt)
      SCAN: begin
        if (psc == PSC_LAST) begin
          psc_nxt  = '0;
          tick_nxt = 1'b1;
          if (!bus.hold && adv_ok) begin
            sel_nxt   = adv_sel;
            frame_nxt = (adv_sel <= sel_q);
          end
        end else begin
          psc_nxt = psc + PW'(1);
        end
      end
      MANUAL: begin
        sel_nxt = bus.man_sel;
        psc_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      psc     <= '0;
      sel_q   <= 2'b00;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      psc     <= psc_nxt;
      sel_q   <= sel_nxt;
      tick_q  <= tick_nxt;
      frame_q <= frame_nxt;
    end
  end

  // Manual mode ignores the mask; scanning with every channel masked blanks the display.
  always_comb begin
    an_d = 4'b1111;
    if (state == MANUAL || (state == SCAN && !all_masked))
      an_d = ~(4'b0001 << sel_q);
  end

  assign bus.sel   = sel_q;
  assign bus.an_n  = an_d;
  assign bus.tick  = tick_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_mux_sel_scanner.sv
// Bench for mux_sel_scanner at DIV=4: scenario tasks check timing inline; a tick monitor pops expected steps from a queue.
module tb_mux_sel_scanner;
  localparam int DIV = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic       frame;
    logic [3:0] an_n;
  } step_t;

  logic  clk = 1'b0;
  logic  reset;
  step_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  mux_sel_scanner_if bus();

  mux_sel_scanner #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [3:0] dec(input logic [1:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  task automatic push(input logic [1:0] s, input logic f);
    step_t e;
    e.sel = s; e.frame = f; e.an_n = dec(s);
    exp_q.push_back(e);
  endtask

  task automatic push_blank(input logic [1:0] s);
    step_t e;
    e.sel = s; e.frame = 1'b0; e.an_n = 4'b1111;
    exp_q.push_back(e);
  endtask

  // Inputs change at the falling edge; one step = one rising edge, then sample at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : tick_mon
    step_t e;
    if (reset !== 1'b1 && bus.tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tick_unexpected got sel=%0d frame=%0b", bus.sel, bus.frame);
      end else begin
        e = exp_q.pop_front();
        if ({bus.sel, bus.frame, bus.an_n} !== e) begin
          failures++;
          $display("FAIL tick_step got sel=%0d frame=%0b an_n=%b exp sel=%0d frame=%0b an_n=%b",
                   bus.sel, bus.frame, bus.an_n, e.sel, e.frame, e.an_n);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b0; bus.hold = 1'b0; bus.manual = 1'b0; bus.man_sel = 2'd0;
`ifdef SCAN_MASK_EN
    bus.mask = 4'b0000;
`endif
    step(); step();
    checks++; if (bus.sel !== 2'd0)     begin failures++; $display("FAIL rst_sel got=%0d exp=0", bus.sel); end
    checks++; if (bus.an_n !== 4'b1111) begin failures++; $display("FAIL rst_an_n got=%b exp=1111", bus.an_n); end
    checks++; if (bus.tick !== 1'b0)    begin failures++; $display("FAIL rst_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.frame !== 1'b0)   begin failures++; $display("FAIL rst_frame got=%b exp=0", bus.frame); end
    reset = 1'b0;
    step();
    checks++; if (bus.an_n !== 4'b1111) begin failures++; $display("FAIL idle_an_n got=%b exp=1111", bus.an_n); end
  endtask

  task automatic test_scan();
    logic [1:0] es;
    bus.en = 1'b1;
    push(2'd1, 1'b0); push(2'd2, 1'b0); push(2'd3, 1'b0); push(2'd0, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step();
      es = 2'((c / 4) % 4);
      checks++; if (bus.tick !== (c % 4 == 0)) begin failures++; $display("FAIL scan_tick c=%0d got=%b exp=%b", c, bus.tick, (c % 4 == 0)); end
      checks++; if (bus.an_n !== dec(es)) begin failures++; $display("FAIL scan_an_n c=%0d got=%b exp=%b", c, bus.an_n, dec(es)); end
    end
  endtask

  task automatic test_hold();
    push(2'd1, 1'b0); push(2'd2, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++; if (bus.tick !== (c % 4 == 0)) begin failures++; $display("FAIL pre_hold_tick c=%0d got=%b", c, bus.tick); end
    end
    bus.hold = 1'b1;
    push(2'd2, 1'b0); push(2'd2, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++; if (bus.tick !== (c % 4 == 0)) begin failures++; $display("FAIL hold_tick c=%0d got=%b exp=%b", c, bus.tick, (c % 4 == 0)); end
      checks++; if (bus.sel !== 2'd2 || bus.an_n !== 4'b1011) begin failures++; $display("FAIL hold_sel c=%0d got sel=%0d an_n=%b exp 2/1011", c, bus.sel, bus.an_n); end
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_manual();
    bus.manual = 1'b1; bus.man_sel = 2'd3;
    step();
    checks++; if (bus.sel !== 2'd3 || bus.an_n !== 4'b0111) begin failures++; $display("FAIL man_sel got sel=%0d an_n=%b exp 3/0111", bus.sel, bus.an_n); end
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (bus.tick !== 1'b0 || bus.sel !== 2'd3) begin failures++; $display("FAIL man_hold c=%0d got tick=%b sel=%0d", c, bus.tick, bus.sel); end
    end
    bus.manual = 1'b0;
    push(2'd0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (bus.tick !== (c == 4)) begin failures++; $display("FAIL man_exit_tick c=%0d got=%b exp=%b", c, bus.tick, (c == 4)); end
    end
    checks++; if (bus.frame !== 1'b1 || bus.sel !== 2'd0) begin failures++; $display("FAIL man_exit_frame got frame=%b sel=%0d exp 1/0", bus.frame, bus.sel); end
  endtask

  task automatic test_idle();
    step(); step();
    // en=0 must win over manual=1 on the same edge
    bus.en = 1'b0; bus.manual = 1'b1; bus.man_sel = 2'd3;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++; if (bus.an_n !== 4'b1111 || bus.sel !== 2'd0 || bus.tick !== 1'b0) begin
        failures++; $display("FAIL idle_freeze c=%0d got an_n=%b sel=%0d tick=%b exp 1111/0/0", c, bus.an_n, bus.sel, bus.tick);
      end
    end
    bus.en = 1'b1; bus.manual = 1'b0;
    push(2'd1, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++; if (bus.tick !== (c == 2)) begin failures++; $display("FAIL idle_resume_tick c=%0d got=%b exp=%b", c, bus.tick, (c == 2)); end
    end
  endtask

  task automatic test_reset_mid();
    push(2'd2, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++; if (bus.tick !== (c == 4)) begin failures++; $display("FAIL pre_rst_tick c=%0d got=%b", c, bus.tick); end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.sel !== 2'd0 || bus.an_n !== 4'b1111 || bus.tick !== 1'b0 || bus.frame !== 1'b0) begin
      failures++; $display("FAIL async_rst got sel=%0d an_n=%b tick=%b frame=%b exp 0/1111/0/0", bus.sel, bus.an_n, bus.tick, bus.frame);
    end
    @(negedge clk);
    step();
    reset = 1'b0;
    push(2'd1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (bus.tick !== (c == 4)) begin failures++; $display("FAIL post_rst_tick c=%0d got=%b exp=%b", c, bus.tick, (c == 4)); end
    end
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask();
    bus.mask = 4'b1010;
    push(2'd2, 1'b0); push(2'd0, 1'b1); push(2'd2, 1'b0); push(2'd0, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++; if (bus.tick !== (c % 4 == 0)) begin failures++; $display("FAIL mask_tick c=%0d got=%b", c, bus.tick); end
    end
    bus.mask = 4'b1111;
    push_blank(2'd0); push_blank(2'd0);
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++; if (bus.an_n !== 4'b1111 || bus.sel !== 2'd0 || bus.tick !== (c % 4 == 0)) begin
        failures++; $display("FAIL mask_all c=%0d got an_n=%b sel=%0d tick=%b", c, bus.an_n, bus.sel, bus.tick);
      end
    end
    bus.mask = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_hold();
    test_manual();
    test_idle();
    test_reset_mid();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_ticks got pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_sel_scanner.md
MUX_SEL_SCANNER -- requirements
Module: mux_sel_scanner

Interface
REQ-001 Parameter DIV, default 100000, SHALL be the prescaler terminal count in clk cycles per scan step; legal range 2..2^24.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 en  input  1  SHALL enable scanning; 0 blanks outputs and freezes the block.
REQ-005 hold  input  1  SHALL, while 1 in SCAN, freeze sel; the prescaler keeps running.
REQ-006 manual  input  1  SHALL select manual mode, sel driven from man_sel.
REQ-007 man_sel  input  2  SHALL be the channel index used in manual mode.
REQ-008 mask  input  4  SHALL be the per-channel skip mask, 1 = skip; present only when SCAN_MASK_EN is defined.
REQ-009 sel  output  2  SHALL be the registered channel index driving the downstream 4:1 mux select.
REQ-010 an_n  output  4  SHALL be the active-low one-hot channel enable, decoded from state and sel with no added latency.
REQ-011 tick  output  1  SHALL be a one-cycle registered pulse marking each scan step.
REQ-012 frame  output  1  SHALL be a one-cycle registered pulse marking a scan wrap.

Function
REQ-013 FSM SHALL have states IDLE, SCAN, MANUAL; each edge: en=0 -> IDLE; else manual=1 -> MANUAL; else SCAN (priority in that order).
REQ-014 IDLE SHALL hold sel and prescaler, force tick=0, frame=0, an_n=4'b1111.
REQ-015 SCAN prescaler SHALL count 0..DIV-1 and wrap to 0; width ceil(log2(DIV)) bits.
REQ-016 On the edge where prescaler==DIV-1 in SCAN, tick SHALL register 1, and if hold=0 sel SHALL register the next channel on that same edge.
REQ-017 Next channel without masking SHALL be (sel+1) mod 4, i.e. 0,1,2,3,0,...
REQ-018 frame SHALL register 1 on the same edge as tick when the advance wraps (next index <= current index); hold=1 SHALL suppress frame but not tick.
REQ-019 In SCAN and MANUAL, an_n SHALL equal ~(4'b0001 << sel).
REQ-020 MANUAL SHALL register sel <= man_sel every cycle (1-cycle latency), hold prescaler at 0, force tick=0, frame=0.
REQ-021 MANUAL -> SCAN SHALL resume scanning from current sel with a full DIV-cycle period before the first tick.
REQ-022 IDLE -> SCAN SHALL resume with the prescaler value frozen at entry to IDLE.
REQ-023 en and manual changing on the same edge SHALL resolve by REQ-013 priority only.

Reset
REQ-024 reset=1 SHALL immediately, independent of clk, set state=IDLE, sel=2'b00, prescaler=0, tick=0, frame=0, an_n=4'b1111.
REQ-025 reset asserted mid-step SHALL discard the partial prescaler count; after release, first tick occurs DIV cycles after entering SCAN.

Configuration
REQ-026 Macro SCAN_MASK_EN SHALL, when defined, add port mask and make SCAN advance to the next unmasked channel in ascending wrap order from sel.
REQ-027 With SCAN_MASK_EN, all four channels masked SHALL hold sel, keep tick pulsing, suppress frame, and force an_n=4'b1111 in SCAN.
REQ-028 With SCAN_MASK_EN, a channel masked while selected SHALL stay displayed until the next tick; MANUAL SHALL ignore mask.
REQ-029 Without SCAN_MASK_EN, port mask SHALL not exist and all four channels SHALL be visited.

Verification (DIV=4)
REQ-030 reset pulse, en=1, manual=0, hold=0 for 20 cycles -> sel 0,1,2,3,0 with tick every 4th cycle, frame only with the 3->0 step, an_n 1110,1101,1011,0111,1110.
REQ-031 hold=1 across two tick edges at sel=2 -> tick still pulses, sel stays 2, an_n=1011, no frame.
REQ-032 manual=1, man_sel=3 -> sel=3 one cycle later, tick=0; manual=0 -> next tick exactly 4 cycles later, sel=0 with frame=1.
REQ-033 en=0 mid-step (prescaler=2) -> an_n=1111, sel frozen; en=1 -> tick 2 cycles after SCAN re-entry.
REQ-034 SCAN_MASK_EN defined, mask=4'b1010 -> sel 0,2,0,2, frame on each 2->0 step; mask=4'b1111 -> sel held, an_n=1111.
REQ-035 reset asserted between clock edges mid-scan -> outputs reach reset values before the next edge; scan restarts at sel=0.
